// File: rtl/key_serializer.sv
// Button debouncer plus frame-synchronised serial key transmitter.
// Each csync reloads the word; each csync-low pvalid slot sends one bit, MSB first.
module key_serializer #(
  parameter int unsigned DB_CYCLES = 16384,
  parameter logic [7:0]  INVERT    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csync,
  input  logic       pvalid,
  input  logic [7:0] buttons,
  output logic       skey,
  output logic       busy,
  output logic       word_done,
  output logic [7:0] debounced
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [7:0]  sync1, sync2;
  logic [15:0] db_cnt [8];
  logic [1:0]  state;
  logic [7:0]  sr;
  logic [3:0]  bitcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

  // Counter runs only while the synchronized level disagrees with the debounced one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debounced <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == debounced[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          debounced[i] <= sync2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // csync wins over pvalid and aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bitcnt    <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (csync) begin
        sr     <= debounced ^ INVERT;
        bitcnt <= '0;
        state  <= LOAD;
      end else if (pvalid && (state == LOAD || state == SHIFT) && bitcnt < 4'd8) begin
        sr     <= {sr[6:0], 1'b0};
        bitcnt <= bitcnt + 4'd1;
        if (bitcnt == 4'd7) begin
          state     <= DONE;
          word_done <= 1'b1;
        end else begin
          state <= SHIFT;
        end
      end
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);
  assign skey = busy ? sr[7] : 1'b0;

endmodule
